arg_value_parser: RTL and testbench
===================================

ARG_VALUE_PARSER -- requirements
Module: arg_value_parser

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the decoded value.
REQ-002 Parameter KEY, default "trace", ASCII key name to match, packed 8 bits per char, first char in the most significant byte.
REQ-003 Parameter KEY_LEN, default 5, number of characters in KEY (1..16).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_l  input  1  reset, asynchronous and active-low.
REQ-006 radix_dec  input  1  value format: 1 = decimal (%d), 0 = binary (%b).
REQ-007 ch_valid  input  1  character-stream valid.
REQ-008 ch_data  input  8  ASCII character.
REQ-009 ch_last  input  1  marks final character of the current argument.
REQ-010 ch_ready  output  1  parser can accept a character this cycle.
REQ-011 res_valid  output  1  result available; held until accepted.
REQ-012 res_ready  input  1  downstream accepts result.
REQ-013 res_found  output  1  1 = argument matched "+KEY=" with a legal value.
REQ-014 res_value  output  WIDTH  decoded value; meaningful when res_found=1.
REQ-015 arg_count  output  8  number of arguments completed; saturates at 255.

Function
REQ-016 A character transfers when ch_valid && ch_ready; no other cycle changes parse state.
REQ-017 ch_ready = !res_valid; the parser stalls input while a result is pending.
REQ-018 radix_dec is sampled on the first transfer of each argument and held for the rest of that argument.
REQ-019 States: PLUS, KEYM, EQ, DIGITS, SKIP; reset state PLUS with key index 0.
REQ-020 PLUS: '+' -> KEYM; any other char -> SKIP.
REQ-021 KEYM: a char equal to KEY[index] increments index; on index reaching KEY_LEN -> EQ; a mismatch -> SKIP.
REQ-022 EQ: '=' -> DIGITS with the accumulator cleared and the digit counter at 0; any other char -> SKIP.
REQ-023 DIGITS, decimal: '0'..'9' -> acc = acc*10 + digit, modulo 2^WIDTH (wrap, no saturation).
REQ-024 DIGITS, binary: '0'/'1' -> acc = {acc[WIDTH-2:0], bit}; higher bits are discarded.
REQ-025 DIGITS: '_' is ignored; any other char (including '2'..'9' in binary) marks the argument invalid -> SKIP.
REQ-026 SKIP consumes characters without effect until ch_last.
REQ-027 On a transfer with ch_last=1, the final character is processed first; then, next cycle, res_valid=1 and the state returns to PLUS.
REQ-028 res_found=1 only if the final state is DIGITS and at least one digit was accepted; otherwise res_found=0.
REQ-029 res_value loads acc only when res_found=1; otherwise it holds its previous value.
REQ-030 res_valid clears on the cycle after res_valid && res_ready; the next character may transfer in that same following cycle.
REQ-031 arg_count increments by 1 on each result, saturating at 255.
REQ-032 ch_last on any state completes the argument. Examples: "+tr" with last gives found=0; "+" alone gives found=0.
REQ-033 ch_data is ignored when ch_valid=0; ch_last is ignored without a transfer.

Reset
REQ-034 While reset_l=0, independent of clk, all outputs and state clear:
- res_valid=0, res_found=0, res_value=0, arg_count=0
- ch_ready=1 once reset_l=1
- state PLUS, accumulator 0
REQ-035 Reset asserted mid-argument discards the partial argument; no result is produced for it.

Verification
REQ-036 Decimal match: "+trace=42" with radix_dec=1 -> one res_valid, found=1, value=42, arg_count=1.
REQ-037 Binary and invalid binary:
- "+trace=1_01" with radix_dec=0 -> found=1, value=5.
- Next "+trace=12" -> found=0, value stays 5.
REQ-038 Key mismatch and empty value:
- "+tracex=1" -> found=0.
- "+trace=" -> found=0.
- "trace=1" (no '+') -> found=0.
- arg_count=3 after all three.
REQ-039 Wrap, WIDTH=8: "+trace=300" decimal -> value=44.
REQ-040 Backpressure: hold res_ready=0 for 5 cycles with ch_valid=1 -> ch_ready=0 throughout, no char lost, second argument parses correctly after acceptance.
REQ-041 Reset mid-argument: assert reset_l=0 after "+tra" -> all outputs 0 immediately; then "+trace=1" -> found=1, value=1, arg_count=1.

Source files
------------

// File: rtl/arg_value_parser.sv
// arg_value_parser: streaming "+KEY=<value>" argument matcher with decimal/binary value decode
//   clk, reset_l            : clock, asynchronous active-low reset
//   radix_dec               : 1 = decimal value, 0 = binary (captured on first char of an argument)
//   ch_valid/ch_data/ch_last: character stream in, ch_last marks the final char of an argument
//   ch_ready                : low while a result is pending
//   res_valid/res_ready     : result handshake
//   res_found/res_value     : match flag and decoded value (value held when not found)
//   arg_count               : completed arguments, saturating at 255
module arg_value_parser #(
    parameter int WIDTH = 32,
    parameter logic [127:0] KEY = "trace",
    parameter int KEY_LEN = 5
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             radix_dec,
    input  logic             ch_valid,
    input  logic [7:0]       ch_data,
    input  logic             ch_last,
    output logic             ch_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [WIDTH-1:0] res_value,
    output logic [7:0]       arg_count
);
    typedef enum logic [2:0] {PLUS, KEYM, EQ, DIGITS, SKIP} state_t;
    state_t state, state_n;
    logic [3:0] idx, idx_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic got_digit, got_digit_n, dec_q, dec, xfer, done, found, is_digit, key_hit, key_done;
    logic [7:0] key_ch;
    assign ch_ready = !res_valid;
    assign xfer = ch_valid && ch_ready;
    assign done = xfer && ch_last;
    // the radix applies from the first character, before dec_q has captured it
    assign dec = (state == PLUS) ? radix_dec : dec_q;
    assign is_digit = dec ? (ch_data >= 8'h30 && ch_data <= 8'h39) : (ch_data == 8'h30 || ch_data == 8'h31);
    // KEY is right-justified, so the first character sits in byte KEY_LEN-1
    assign key_ch = 8'(KEY >> (8 * (KEY_LEN - 1 - int'(idx))));
    assign key_hit = ch_data == key_ch;
    assign key_done = int'(idx) == KEY_LEN - 1;
    always_comb begin
        state_n = state;
        idx_n = idx;
        acc_n = acc;
        got_digit_n = got_digit;
        if (xfer) begin
            case (state)
                PLUS: state_n = (ch_data == 8'h2b) ? KEYM : SKIP;
                KEYM: begin
                    state_n = !key_hit ? SKIP : key_done ? EQ : KEYM;
                    idx_n = (key_hit && !key_done) ? idx + 4'd1 : 4'd0;
                end
                EQ: begin
                    state_n = (ch_data == 8'h3d) ? DIGITS : SKIP;
                    acc_n = '0;
                    got_digit_n = 1'b0;
                end
                DIGITS: begin
                    acc_n = !is_digit ? acc : dec ? (acc << 3) + (acc << 1) + WIDTH'(ch_data - 8'h30)
                                                 : {acc[WIDTH-2:0], ch_data[0]};
                    got_digit_n = got_digit || is_digit;
                    state_n = (is_digit || ch_data == 8'h5f) ? DIGITS : SKIP;
                end
                default: state_n = SKIP;
            endcase
        end
        found = state_n == DIGITS && got_digit_n;
        if (done) begin
            state_n = PLUS;
            idx_n = 4'd0;
            got_digit_n = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= PLUS;
            idx <= 4'd0;
            acc <= '0;
            got_digit <= 1'b0;
            dec_q <= 1'b0;
            res_valid <= 1'b0;
            res_found <= 1'b0;
            res_value <= '0;
            arg_count <= 8'd0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            acc <= acc_n;
            got_digit <= got_digit_n;
            if (xfer && state == PLUS) dec_q <= radix_dec;
            if (res_valid && res_ready) res_valid <= 1'b0;
            if (done) begin
                res_valid <= 1'b1;
                res_found <= found;
                if (found) res_value <= acc_n;
                arg_count <= arg_count + {7'd0, arg_count != 8'hff};
            end
        end
    end
endmodule

// File: tb/tb_arg_value_parser.sv
// tb_arg_value_parser: randomized and directed checks of arg_value_parser against a string-level model
module tb_arg_value_parser;
    logic clk = 1'b0, reset_l = 1'b0, radix_dec = 1'b1, ch_valid = 1'b0, ch_last = 1'b0, res_ready = 1'b0;
    logic [7:0] ch_data = 8'd0;
    logic ch_ready, res_valid, res_found, ch_ready8, res_valid8, res_found8;
    logic [31:0] res_value;
    logic [7:0] res_value8, arg_count, arg_count8;
    int checks = 0, errors = 0, exp_cnt = 0;
    logic [63:0] exp_v = 64'd0;
    always #5 clk = ~clk;
    arg_value_parser dut (.clk(clk), .reset_l(reset_l), .radix_dec(radix_dec), .ch_valid(ch_valid),
        .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_found(res_found), .res_value(res_value), .arg_count(arg_count));
    arg_value_parser #(.WIDTH(8)) dut8 (.clk(clk), .reset_l(reset_l), .radix_dec(radix_dec), .ch_valid(ch_valid),
        .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready8), .res_valid(res_valid8),
        .res_ready(res_ready), .res_found(res_found8), .res_value(res_value8), .arg_count(arg_count8));
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // whole-argument reference: "+trace=" then digits/underscores only, at least one digit
    function automatic void model(input logic [7:0] q[$], input bit dec, output bit f, output logic [63:0] v);
        string pre = "+trace=";
        int nd = 0;
        f = 1'b0;
        v = 64'd0;
        if (q.size() < 7) return;
        for (int i = 0; i < 7; i++) if (q[i] != pre[i]) return;
        for (int i = 7; i < q.size(); i++) begin
            if (q[i] == "_") continue;
            if (dec && q[i] >= "0" && q[i] <= "9") v = v * 10 + 64'(q[i] - 8'h30);
            else if (!dec && (q[i] == "0" || q[i] == "1")) v = v * 2 + 64'(q[i] - 8'h30);
            else return;
            nd++;
        end
        f = nd > 0;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send_char(input logic [7:0] c, input bit last, input bit dec);
        int n = 0;
        ch_valid = 1'b1;
        ch_data = c;
        ch_last = last;
        radix_dec = dec;
        while (!ch_ready && n < 50) begin
            tick();
            n++;
        end
        if (!ch_ready) check("ch_ready_timeout", 64'(ch_ready), 64'd1);
        tick();
        ch_valid = 1'b0;
    endtask
    task automatic gap;
        repeat ($urandom_range(0, 2)) begin
            ch_data = 8'($urandom);
            ch_last = 1'($urandom);
            tick();
        end
    endtask
    task automatic accept(input int stall);
        ch_valid = 1'b1;
        ch_data = 8'($urandom);
        ch_last = 1'($urandom);
        repeat (stall) begin
            tick();
            check("stall_ch_ready", 64'(ch_ready), 64'd0);
            check("stall_res_valid", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ch_valid = 1'b0;
        check("res_valid_clear", 64'(res_valid), 64'd0);
        check("ch_ready_back", 64'(ch_ready), 64'd1);
    endtask
    task automatic send_q(input logic [7:0] q[$], input bit dec);
        bit f;
        logic [63:0] v;
        for (int i = 0; i < q.size(); i++) begin
            send_char(q[i], i == q.size() - 1, i == 0 ? dec : 1'($urandom));
            if (i != q.size() - 1) gap();
        end
        model(q, dec, f, v);
        if (f) exp_v = v;
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        check("res_valid", 64'(res_valid), 64'd1);
        check("res_found", 64'(res_found), 64'(f));
        check("res_value", 64'(res_value), 64'(exp_v[31:0]));
        check("arg_count", 64'(arg_count), 64'(exp_cnt));
        check("res_valid8", 64'(res_valid8), 64'd1);
        check("res_found8", 64'(res_found8), 64'(f));
        check("res_value8", 64'(res_value8), 64'(exp_v[7:0]));
        check("arg_count8", 64'(arg_count8), 64'(exp_cnt));
        accept($urandom_range(0, 5));
    endtask
    task automatic send_str(input string s, input bit dec);
        logic [7:0] q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        send_q(q, dec);
    endtask
    task automatic gen(output logic [7:0] q[$], output bit dec);
        string pre = "+trace=", junk = "+tracex=9", bad = "29z+";
        string alpha;
        int k = $urandom_range(0, 9);
        dec = 1'($urandom);
        alpha = dec ? "0123456789_" : "01_";
        q = {};
        if (k < 8) for (int i = 0; i < 7; i++) q.push_back(pre[i]);
        if (k == 7) q[$urandom_range(0, 6)] = junk[$urandom_range(0, junk.len() - 1)];
        if (k >= 8) repeat ($urandom_range(1, 6)) q.push_back(junk[$urandom_range(0, junk.len() - 1)]);
        repeat ($urandom_range(0, 8))
            q.push_back(($urandom_range(0, 14) == 0) ? bad[$urandom_range(0, 3)] : alpha[$urandom_range(0, alpha.len() - 1)]);
        if (q.size() == 0) q.push_back(8'h2b);
    endtask
    initial begin
        logic [7:0] q[$];
        bit dec;
        repeat (3) tick();
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_found", 64'(res_found), 64'd0);
        check("rst_res_value", 64'(res_value), 64'd0);
        check("rst_arg_count", 64'(arg_count), 64'd0);
        reset_l = 1'b1;
        tick();
        check("rst_ch_ready", 64'(ch_ready), 64'd1);
        send_str("+trace=42", 1'b1);
        send_str("+trace=1_01", 1'b0);
        send_str("+trace=12", 1'b0);
        send_str("+tracex=1", 1'b1);
        send_str("+trace=", 1'b1);
        send_str("trace=1", 1'b1);
        send_str("+trace=300", 1'b1);
        send_str("+tr", 1'b1);
        send_str("+", 1'b1);
        send_str("+trace=_1_1_0", 1'b0);
        send_char("+", 1'b0, 1'b1);
        send_char("t", 1'b0, 1'b1);
        send_char("r", 1'b0, 1'b1);
        send_char("a", 1'b0, 1'b1);
        reset_l = 1'b0;
        #1;
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_res_found", 64'(res_found), 64'd0);
        check("mid_rst_res_value", 64'(res_value), 64'd0);
        check("mid_rst_arg_count", 64'(arg_count), 64'd0);
        check("mid_rst_res_value8", 64'(res_value8), 64'd0);
        exp_cnt = 0;
        exp_v = 64'd0;
        tick();
        reset_l = 1'b1;
        tick();
        send_str("+trace=1", 1'b1);
        repeat (300) begin
            gen(q, dec);
            send_q(q, dec);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
